node_mac_seq: RTL and testbench

- Parametrised, time-multiplexed successor to the fixed 15-input fully-parallel layer node.
- Accepts one signed activation per cycle over a valid/ready stream and multiplies it by a runtime-loaded weight using one shared MAC.
- After N_IN activations, adds the bias, rounds and shifts the result, applies ReLU or linear activation, saturates, and presents one DATA_W output on a valid/ready stream.
- Weights and bias come from a config write port, so one RTL block serves every node in every layer.

---
 rtl/node_pkg.sv | 19 +
 rtl/node_act_round.sv | 48 ++++
 rtl/node_mac_seq.sv | 143 ++++++++++++++
 tb/tb_node_mac_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/node_pkg.sv
// Shared types and constants for the sequential MAC node.
// Holds the FSM state enum, activation-mode codes and ACC_W sizing.
package node_pkg;

  typedef enum logic [1:0] {
    ACCUM,
    FINISH,
    OUTPUT
  } state_t;

  localparam logic ACT_RELU   = 1'b0;
  localparam logic ACT_LINEAR = 1'b1;

  // Smallest accumulator holding N_IN full-width products plus bias.
  function automatic int acc_w_min(input int data_w, input int n_in);
    return 2 * data_w + $clog2(n_in) + 1;
  endfunction

endpackage

// File: rtl/node_act_round.sv
// Combinational round, shift, activation and saturation stage.
// Ports: s_i (acc+bias), act_mode_i -> y_o (result), sat_o (clamp hit).
module node_act_round
  import node_pkg::*;
#(
  parameter int ACC_W      = 24,
  parameter int DATA_W     = 8,
  parameter int FRAC_SHIFT = 6
) (
  input  logic signed [ACC_W-1:0]  s_i,
  input  logic                     act_mode_i,
  output logic signed [DATA_W-1:0] y_o,
  output logic                     sat_o
);

  // One guard bit so the rounding add can never wrap.
  localparam int RW = ACC_W + 1;

  localparam logic signed [RW-1:0] HALF =
    {{(RW-1){1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
  localparam logic signed [RW-1:0] MAXV =
    {{(RW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV =
    {{(RW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [RW-1:0] sum;
  logic signed [RW-1:0] r;

  always_comb begin
    sum   = {s_i[ACC_W-1], s_i} + HALF;
    r     = sum >>> FRAC_SHIFT;
    y_o   = r[DATA_W-1:0];
    sat_o = 1'b0;
    if (r > MAXV) begin
      y_o   = MAXV[DATA_W-1:0];
      sat_o = 1'b1;
    end else if (r[RW-1]) begin
      // ReLU zeroing is the activation, not a clamp.
      if (act_mode_i == ACT_RELU) begin
        y_o = '0;
      end else if (r < MINV) begin
        y_o   = MINV[DATA_W-1:0];
        sat_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/node_mac_seq.sv
// Time-multiplexed neural node: one shared MAC, runtime weights/bias.
// Ports: cfg/bias write, in_* and out_* valid/ready streams; NODE_SAT_FLAG_EN adds sat_flag.
module node_mac_seq
  import node_pkg::*;
#(
  parameter int N_IN       = 15,
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 24,
  parameter int FRAC_SHIFT = 6,
  localparam int AW        = $clog2(N_IN)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       act_mode,
  input  logic                       cfg_we,
  input  logic [AW-1:0]              cfg_addr,
  input  logic signed [DATA_W-1:0]   cfg_wdata,
  input  logic                       bias_we,
  input  logic signed [2*DATA_W-1:0] bias_wdata,
  output logic                       cfg_ready,
  input  logic                       in_valid,
  input  logic signed [DATA_W-1:0]   in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic signed [DATA_W-1:0]   out_data,
  input  logic                       out_ready
`ifdef NODE_SAT_FLAG_EN
  ,
  output logic                       sat_flag
`endif
);

  if (ACC_W < acc_w_min(DATA_W, N_IN)) begin : g_acc_chk
    $error("node_mac_seq: ACC_W too small for DATA_W/N_IN");
  end

  localparam int PW = 2 * DATA_W;
  localparam logic [AW-1:0] LAST  = AW'(N_IN - 1);
  localparam logic [AW:0]   NIN_L = (AW+1)'(N_IN);

  state_t                   state_q;
  logic [AW-1:0]            idx_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [DATA_W-1:0] w_q [N_IN];
  logic signed [PW-1:0]     bias_q;
  logic                     in_ready_q;
  logic                     out_valid_q;
  logic signed [DATA_W-1:0] out_data_q;

  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  s_d;
  logic signed [DATA_W-1:0] y_d;
  logic                     sat_d;
  logic                     hs;

  assign prod     = in_data * w_q[idx_q];
  assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
  assign bias_ext = {{(ACC_W-PW){bias_q[PW-1]}}, bias_q};
  assign s_d      = acc_q + bias_ext;
  assign hs       = in_valid && in_ready_q;

  assign cfg_ready = (state_q == ACCUM) && (idx_q == '0);
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  node_act_round #(
    .ACC_W      (ACC_W),
    .DATA_W     (DATA_W),
    .FRAC_SHIFT (FRAC_SHIFT)
  ) u_act (
    .s_i        (s_d),
    .act_mode_i (act_mode),
    .y_o        (y_d),
    .sat_o      (sat_d)
  );

`ifdef NODE_SAT_FLAG_EN
  logic sat_q;
  assign sat_flag = sat_q;
`else
  logic sat_unused;
  assign sat_unused = sat_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ACCUM;
      idx_q       <= '0;
      acc_q       <= '0;
      bias_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < N_IN; i++) w_q[i] <= '0;
`ifdef NODE_SAT_FLAG_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      // Old values feed a handshake that coincides with a write.
      if (cfg_we && cfg_ready && ({1'b0, cfg_addr} < NIN_L))
        w_q[cfg_addr] <= cfg_wdata;
      if (bias_we && cfg_ready)
        bias_q <= bias_wdata;

      unique case (state_q)
        ACCUM: begin
          in_ready_q <= 1'b1;
          if (hs) begin
            acc_q <= acc_q + prod_ext;
            if (idx_q == LAST) begin
              idx_q      <= '0;
              state_q    <= FINISH;
              in_ready_q <= 1'b0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        FINISH: begin
          out_data_q  <= y_d;
          out_valid_q <= 1'b1;
          state_q     <= OUTPUT;
`ifdef NODE_SAT_FLAG_EN
          sat_q       <= sat_d;
`endif
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            state_q     <= ACCUM;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_node_mac_seq.sv
// Scoreboard bench for node_mac_seq: directed vectors, queued expectations.
// Driver pushes expected results; a negedge monitor pops and compares.
module tb_node_mac_seq;

  logic              clk;
  logic              reset;
  logic              act_mode;
  logic              cfg_we;
  logic [3:0]        cfg_addr;
  logic signed [7:0] cfg_wdata;
  logic              bias_we;
  logic signed [15:0] bias_wdata;
  logic              cfg_ready;
  logic              in_valid;
  logic signed [7:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic signed [7:0] out_data;
  logic              out_ready;
`ifdef NODE_SAT_FLAG_EN
  logic              sat_flag;
`endif

  node_mac_seq dut (
    .clk        (clk),
    .reset      (reset),
    .act_mode   (act_mode),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .bias_we    (bias_we),
    .bias_wdata (bias_wdata),
    .cfg_ready  (cfg_ready),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready)
`ifdef NODE_SAT_FLAG_EN
    ,
    .sat_flag   (sat_flag)
`endif
  );

  typedef struct {
    int data;
    bit sat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   hs_cyc  = 0;
  bit   seen    = 0;

  int w1[15] = '{-28, 2, -34, 34, 6, 18, -40, 56, -14, -56, 18, -18, 22, 32, 6};
  int wmax[15] = '{default: 127};
  int wneg[15] = '{default: -1};
  int wz[15]   = '{default: 0};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  // Monitor: latency on first sight of out_valid, data on handshake.
  always @(negedge clk) begin
    if (!reset) begin
      seen = 0;
    end else if (out_valid) begin
      if (!seen) begin
        seen = 1;
        chk("latency", cyc - hs_cyc, 2);
      end
      if (out_ready) begin
        seen = 0;
        if (sb.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_data", int'(out_data), e.data);
`ifdef NODE_SAT_FLAG_EN
          chk("sat_flag", int'(sat_flag), int'(e.sat));
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cfg();
    int n = 0;
    while (!cfg_ready && n < 100) begin
      tick();
      n++;
    end
    if (!cfg_ready) chk("cfg_ready_timeout", 0, 1);
  endtask

  task automatic load(input int w[15], input int bias);
    wait_cfg();
    for (int i = 0; i < 15; i++) begin
      cfg_we    = 1'b1;
      cfg_addr  = 4'(i);
      cfg_wdata = 8'(w[i]);
      tick();
    end
    cfg_we     = 1'b0;
    bias_we    = 1'b1;
    bias_wdata = 16'(bias);
    tick();
    bias_we = 1'b0;
  endtask

  task automatic send(input int a);
    int n = 0;
    in_valid = 1'b1;
    in_data  = 8'(a);
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    hs_cyc = cyc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic run(input int w[15], input int bias, input bit ld,
                     input logic mode, input int a, input int exp,
                     input bit exp_sat, input bit hold);
    exp_t e;
    int n = 0;
    if (ld) load(w, bias);
    act_mode = mode;
    e.data = exp;
    e.sat  = exp_sat;
    sb.push_back(e);
    if (hold) out_ready = 1'b0;
    for (int i = 0; i < 15; i++) send(a);
    if (hold) begin
      while (!out_valid && n < 20) begin
        tick();
        n++;
      end
      for (int k = 0; k < 5; k++) begin
        chk("bp_valid", int'(out_valid), 1);
        chk("bp_data", int'(out_data), exp);
        chk("bp_in_ready", int'(in_ready), 0);
        chk("bp_cfg_ready", int'(cfg_ready), 0);
        cfg_we     = 1'b1;
        cfg_addr   = 4'd0;
        cfg_wdata  = 8'sd100;
        bias_we    = 1'b1;
        bias_wdata = 16'sd1000;
        tick();
      end
      cfg_we    = 1'b0;
      bias_we   = 1'b0;
      out_ready = 1'b1;
    end
    drain();
  endtask

  initial begin
    reset      = 1'b0;
    act_mode   = 1'b0;
    cfg_we     = 1'b0;
    cfg_addr   = '0;
    cfg_wdata  = '0;
    bias_we    = 1'b0;
    bias_wdata = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b1;
    repeat (2) tick();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    reset = 1'b1;
    tick();
    chk("post_rst_in_ready", int'(in_ready), 1);
    chk("post_rst_cfg_ready", int'(cfg_ready), 1);

    // Fan-in and rounding: sum(w)=4, 4*64+512=768 -> 12
    run(w1, 512, 1, 1'b0, 64, 12, 0, 0);
    // Positive saturation in both modes
    run(wmax, 0, 1, 1'b0, 127, 127, 1, 0);
    run(wmax, 0, 0, 1'b1, 127, 127, 1, 0);
    // Negative path: -960 -> relu 0, linear -15
    run(wneg, 0, 1, 1'b0, 64, 0, 0, 0);
    run(wneg, 0, 0, 1'b1, 64, -15, 0, 0);
    // Rounding boundary with zero weights
    run(wz, 32, 1, 1'b0, 64, 1, 0, 0);
    run(wz, 31, 1, 1'b0, 64, 0, 0, 0);
    run(wz, -32, 1, 1'b1, 64, 0, 0, 0);
    run(wz, -33, 1, 1'b1, 64, -1, 0, 0);
    // Backpressure, then rerun without reload: blocked writes must not land
    run(w1, 512, 1, 1'b0, 64, 12, 0, 1);
    run(w1, 512, 0, 1'b0, 64, 12, 0, 0);

    // Reset after 7 inputs, reload and replay
    act_mode = 1'b0;
    for (int i = 0; i < 7; i++) send(64);
    reset = 1'b0;
    tick();
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    reset = 1'b1;
    tick();
    run(w1, 512, 1, 1'b0, 64, 12, 0, 0);

    // Reset clears weights and bias: no reload gives 0
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    run(wz, 0, 0, 1'b1, 64, 0, 0, 0);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
